// File: rtl/multicycle_sequencer_pkg.sv
// Shared definitions for the multicycle sequencer.
//   state_t   : FSM state encoding, also exported on the debug 'state' port
//   OP_*      : 3-bit opcodes produced by instruction decode
//   is_alu()  : true for the register/immediate ALU opcodes (000..011)
package seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEMORY    = 3'd4,
        S_WRITEBACK = 3'd5,
        S_HALT      = 3'd6
    } state_t;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_FETCH     = 3'd1;
    localparam logic [2:0] ST_DECODE    = 3'd2;
    localparam logic [2:0] ST_EXECUTE   = 3'd3;
    localparam logic [2:0] ST_MEMORY    = 3'd4;
    localparam logic [2:0] ST_WRITEBACK = 3'd5;
    localparam logic [2:0] ST_HALT      = 3'd6;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_ADDI = 3'b010;
    localparam logic [2:0] OP_SUBI = 3'b011;
    localparam logic [2:0] OP_LW   = 3'b100;
    localparam logic [2:0] OP_SW   = 3'b101;
    localparam logic [2:0] OP_JUMP = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    function automatic logic is_alu(input logic [2:0] op);
        return (op <= OP_SUBI);
    endfunction

endpackage

// File: rtl/multicycle_sequencer_if.sv
// Control bus between the sequencer and the datapath.
//   slave  : sequencer side (receives start/op_code[/step], drives strobes)
//   master : datapath/controller side
// Optional macro SINGLE_STEP_EN adds the 'step' request, placed after start.
interface multicycle_sequencer_if #(
    parameter int COUNT_W = 16
);
    logic               start;
`ifdef SINGLE_STEP_EN
    logic               step;
`endif
    logic [2:0]         op_code;
    logic               ir_load;
    logic               pc_update;
    logic               jump_take;
    logic               mem_write;
    logic               reg_write;
    logic               wb_sel;
    logic               busy;
    logic               halted;
    logic [2:0]         state;
    logic [COUNT_W-1:0] instr_count;

    modport slave (
        input  start,
`ifdef SINGLE_STEP_EN
        input  step,
`endif
        input  op_code,
        output ir_load, pc_update, jump_take, mem_write, reg_write, wb_sel,
        output busy, halted, state, instr_count
    );

    modport master (
        output start,
`ifdef SINGLE_STEP_EN
        output step,
`endif
        output op_code,
        input  ir_load, pc_update, jump_take, mem_write, reg_write, wb_sel,
        input  busy, halted, state, instr_count
    );
endinterface

// File: rtl/multicycle_sequencer.sv
// Multicycle sequencer: steps the 8-bit datapath through
// FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK and counts retired instructions.
// Ports:
//   clock    : system clock, rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : multicycle_sequencer_if.slave (start, [step], op_code in;
//              ir_load, pc_update, jump_take, mem_write, reg_write, wb_sel,
//              busy, halted, state, instr_count out)
// Parameters: MEM_LAT (1..15) memory cycles, COUNT_W retire counter width.
// Optional macro SINGLE_STEP_EN: FETCH waits for a start/step token.
//
// state     | meaning
// IDLE      | waiting for start
// FETCH     | load instruction register
// DECODE    | capture opcode; JUMP retires here, HALT terminates
// EXECUTE   | ALU operation or address calculation
// MEMORY    | MEM_LAT cycles of data-memory access; SW retires on last
// WRITEBACK | register-file write, retire
// HALT      | terminal until reset
module multicycle_sequencer
    import seq_pkg::*;
#(
    parameter int MEM_LAT = 1,
    parameter int COUNT_W = 16
) (
    input  logic clock,
    input  logic reset_n,
    multicycle_sequencer_if.slave bus
);

    state_t             state_q, state_d;
    logic [2:0]         op_q, op_d;
    logic [3:0]         mem_cnt_q, mem_cnt_d;
    logic [COUNT_W-1:0] count_q, count_d;

    logic ir_load, pc_update, jump_take, mem_write, reg_write, wb_sel, retire;
    logic fetch_go;

`ifdef SINGLE_STEP_EN
    logic token_q, token_d;

    // A step in the consuming cycle re-arms the token so that pulse is not lost.
    always_comb begin
        token_d = token_q | bus.step | ((state_q == S_IDLE) & bus.start);
        if ((state_q == S_FETCH) && token_q) begin
            token_d = bus.step;
        end
    end

    assign fetch_go = token_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            token_q <= 1'b0;
        end else begin
            token_q <= token_d;
        end
    end
`else
    assign fetch_go = 1'b1;
`endif

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        mem_cnt_d = mem_cnt_q;
        ir_load   = 1'b0;
        pc_update = 1'b0;
        jump_take = 1'b0;
        mem_write = 1'b0;
        reg_write = 1'b0;
        wb_sel    = 1'b0;
        retire    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (fetch_go) begin
                    ir_load = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                // op_q only becomes valid after this cycle, so the two-cycle
                // JUMP has to steer the PC straight from the live opcode.
                op_d = bus.op_code;
                if (bus.op_code == OP_HALT) begin
                    state_d = S_HALT;
                end else if (bus.op_code == OP_JUMP) begin
                    pc_update = 1'b1;
                    jump_take = 1'b1;
                    retire    = 1'b1;
                    state_d   = S_FETCH;
                end else begin
                    state_d = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                if (is_alu(op_q)) begin
                    state_d = S_WRITEBACK;
                end else begin
                    mem_cnt_d = 4'(MEM_LAT - 1);
                    state_d   = S_MEMORY;
                end
            end
            S_MEMORY: begin
                if (mem_cnt_q == 4'd0) begin
                    if (op_q == OP_SW) begin
                        mem_write = 1'b1;
                        pc_update = 1'b1;
                        retire    = 1'b1;
                        state_d   = S_FETCH;
                    end else begin
                        state_d = S_WRITEBACK;
                    end
                end else begin
                    mem_cnt_d = mem_cnt_q - 4'd1;
                end
            end
            S_WRITEBACK: begin
                reg_write = 1'b1;
                pc_update = 1'b1;
                wb_sel    = (op_q == OP_LW);
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        count_d = retire ? count_q + 1'b1 : count_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            op_q      <= 3'd0;
            mem_cnt_q <= 4'd0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            mem_cnt_q <= mem_cnt_d;
            count_q   <= count_d;
        end
    end

    assign bus.ir_load     = ir_load;
    assign bus.pc_update   = pc_update;
    assign bus.jump_take   = jump_take;
    assign bus.mem_write   = mem_write;
    assign bus.reg_write   = reg_write;
    assign bus.wb_sel      = wb_sel;
    assign bus.busy        = (state_q != S_IDLE) && (state_q != S_HALT);
    assign bus.halted      = (state_q == S_HALT);
    assign bus.state       = state_q;
    assign bus.instr_count = count_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer (MEM_LAT=3, COUNT_W=4).
// Optional macro SINGLE_STEP_EN enables the single-step checks.
module tb_multicycle_sequencer;
    import seq_pkg::*;

    localparam int LAT = 3;
    localparam int CW  = 4;

    logic clock;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    multicycle_sequencer_if #(.COUNT_W(CW)) bus ();

    multicycle_sequencer #(.MEM_LAT(LAT), .COUNT_W(CW)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [2:0] op;
        int         lat;
        int         n_rw;
        int         n_mw;
        int         n_jt;
        int         n_wb;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] all_outs();
        return {14'd0, bus.ir_load, bus.pc_update, bus.jump_take, bus.mem_write,
                bus.reg_write, bus.wb_sel, bus.busy, bus.halted, bus.state, bus.instr_count};
    endfunction

    task automatic start_pulse();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    // Runs one instruction starting in FETCH, tallying strobe cycles.
    task automatic run_instr(input logic [2:0] op, output int cyc, output int n_ir,
                             output int n_pc, output int n_jt, output int n_mw,
                             output int n_rw, output int n_wb, output int n_bad);
        bus.op_code = op;
        cyc = 0; n_ir = 0; n_pc = 0; n_jt = 0; n_mw = 0; n_rw = 0; n_wb = 0; n_bad = 0;
        do begin
            n_ir += int'(bus.ir_load);
            n_pc += int'(bus.pc_update);
            n_jt += int'(bus.jump_take);
            n_mw += int'(bus.mem_write);
            n_rw += int'(bus.reg_write);
            n_wb += int'(bus.wb_sel & bus.reg_write);
            n_bad += int'((bus.mem_write & bus.reg_write) | (bus.jump_take & ~bus.pc_update));
            tick();
            cyc++;
        end while (bus.state != ST_FETCH && bus.state != ST_HALT && cyc < 40);
    endtask

    initial begin
        int cyc, n_ir, n_pc, n_jt, n_mw, n_rw, n_wb, n_bad;
        logic [CW-1:0] cnt0;

        vecs[0] = '{OP_ADD,  4,       1, 0, 0, 0};
        vecs[1] = '{OP_SUB,  4,       1, 0, 0, 0};
        vecs[2] = '{OP_ADDI, 4,       1, 0, 0, 0};
        vecs[3] = '{OP_SUBI, 4,       1, 0, 0, 0};
        vecs[4] = '{OP_LW,   4 + LAT, 1, 0, 0, 1};
        vecs[5] = '{OP_SW,   3 + LAT, 0, 1, 0, 0};
        vecs[6] = '{OP_JUMP, 2,       0, 0, 1, 0};

        reset_n     = 1'b0;
        bus.start   = 1'b0;
        bus.op_code = OP_ADD;
`ifdef SINGLE_STEP_EN
        bus.step    = 1'b1;
`endif
        #1;
        chk("reset_outputs", all_outs(), 32'd0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        chk("idle_state", 32'(bus.state), ST_IDLE);

        start_pulse();
        chk("start_state", 32'(bus.state), ST_FETCH);
        chk("start_ir_load", 32'(bus.ir_load), 1);

        // ADD walked cycle by cycle: 1,2,3,5,1
        tick(); chk("add_decode", 32'(bus.state), ST_DECODE);
        tick(); chk("add_execute", 32'(bus.state), ST_EXECUTE);
        tick(); chk("add_wb_state", 32'(bus.state), ST_WRITEBACK);
        chk("add_wb_strobes", {29'd0, bus.reg_write, bus.wb_sel, bus.pc_update}, 32'b101);
        tick(); chk("add_back_fetch", 32'(bus.state), ST_FETCH);
        chk("add_count", 32'(bus.instr_count), 1);

        for (int i = 0; i < 7; i++) begin
            cnt0 = bus.instr_count;
            run_instr(vecs[i].op, cyc, n_ir, n_pc, n_jt, n_mw, n_rw, n_wb, n_bad);
            chk($sformatf("v%0d_latency", i), 32'(cyc), 32'(vecs[i].lat));
            chk($sformatf("v%0d_ir_load", i), 32'(n_ir), 1);
            chk($sformatf("v%0d_pc_update", i), 32'(n_pc), 1);
            chk($sformatf("v%0d_jump_take", i), 32'(n_jt), 32'(vecs[i].n_jt));
            chk($sformatf("v%0d_mem_write", i), 32'(n_mw), 32'(vecs[i].n_mw));
            chk($sformatf("v%0d_reg_write", i), 32'(n_rw), 32'(vecs[i].n_rw));
            chk($sformatf("v%0d_wb_sel", i), 32'(n_wb), 32'(vecs[i].n_wb));
            chk($sformatf("v%0d_exclusive", i), 32'(n_bad), 0);
            chk($sformatf("v%0d_count", i), 32'(bus.instr_count), 32'(CW'(cnt0 + 1'b1)));
        end

        // SW: mem_write only on the third MEMORY cycle
        bus.op_code = OP_SW;
        tick(); tick(); tick();
        chk("sw_m1_state", 32'(bus.state), ST_MEMORY);
        chk("sw_m1_mw", 32'(bus.mem_write), 0);
        tick();
        chk("sw_m2_state", 32'(bus.state), ST_MEMORY);
        chk("sw_m2_mw", 32'(bus.mem_write), 0);
        tick();
        chk("sw_m3_state", 32'(bus.state), ST_MEMORY);
        chk("sw_m3_mw", 32'(bus.mem_write), 1);
        tick();
        chk("sw_done", 32'(bus.state), ST_FETCH);

        // HALT is terminal, start ignored
        cnt0 = bus.instr_count;
        bus.op_code = OP_HALT;
        tick(); tick();
        chk("halt_state", 32'(bus.state), ST_HALT);
        chk("halt_flags", {30'd0, bus.halted, bus.busy}, 32'b10);
        start_pulse();
        tick(); tick();
        chk("halt_start_ignored", 32'(bus.state), ST_HALT);
        chk("halt_count_held", 32'(bus.instr_count), 32'(cnt0));

        // asynchronous reset out of HALT, then during a live SW write
        #2 reset_n = 1'b0;
        #1 chk("halt_async_reset", all_outs(), 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        bus.op_code = OP_SW;
        start_pulse();
        tick(); tick(); tick(); tick(); tick();
        chk("sw2_m3_mw", 32'(bus.mem_write), 1);
        #2 reset_n = 1'b0;
        #1 chk("sw_async_reset", all_outs(), 32'd0);
        tick();
        reset_n = 1'b1;
        tick();

        // counter wraps from all-ones to zero
        start_pulse();
        for (int i = 0; i < 15; i++) begin
            run_instr(OP_JUMP, cyc, n_ir, n_pc, n_jt, n_mw, n_rw, n_wb, n_bad);
        end
        chk("count_max", 32'(bus.instr_count), 15);
        run_instr(OP_JUMP, cyc, n_ir, n_pc, n_jt, n_mw, n_rw, n_wb, n_bad);
        chk("count_wrap", 32'(bus.instr_count), 0);

`ifdef SINGLE_STEP_EN
        // single step: one step pulse retires exactly one instruction
        #2 reset_n = 1'b0;
        #1;
        bus.step = 1'b0;
        tick();
        reset_n = 1'b1;
        bus.op_code = OP_ADD;
        tick();
        start_pulse();
        run_instr(OP_ADD, cyc, n_ir, n_pc, n_jt, n_mw, n_rw, n_wb, n_bad);
        chk("step_first_count", 32'(bus.instr_count), 1);
        n_ir = 0;
        for (int i = 0; i < 10; i++) begin
            n_ir += int'(bus.ir_load) + int'(bus.state != ST_FETCH);
            tick();
        end
        chk("step_hold", 32'(n_ir), 0);
        bus.step = 1'b1;
        tick();
        bus.step = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        chk("step_one_retire", 32'(bus.instr_count), 2);
        chk("step_held_again", 32'(bus.state), ST_FETCH);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
